// File: rtl/column_event_queue_if.sv
// ----------------------------------------------------------------------------
// column_event_queue_if
// APB3 completer-side bundle for column_event_queue.
//   PSEL/PENABLE/PWRITE : transfer select, access phase, direction
//   PADDR/PWDATA        : address (only [11:0] decoded) and write data
//   PRDATA              : registered read data
//   PREADY/PSLVERR      : always ready, never error
// ----------------------------------------------------------------------------
interface column_event_queue_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/column_event_queue.sv
// ----------------------------------------------------------------------------
// column_event_queue
// Break-beam column sensors -> debounced events -> FIFO drained over APB.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   apb          : APB3 completer (STATUS 0x200, POP 0x204, CTRL 0x208)
//   COL_N        : raw active-low sensors, asynchronous to PCLK
//   IRQ          : registered, high while the event FIFO is not empty
// Optional feature: define LOCKOUT_EN to add a per-column re-trigger lockout
// of LOCKOUT_CYCLES clocks after each pushed or dropped event.
// ----------------------------------------------------------------------------
module column_event_queue #(
    parameter int unsigned NUM_COLS       = 7,
    parameter int unsigned DEBOUNCE_BITS  = 16,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned LOCKOUT_CYCLES = 1000000
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    column_event_queue_if.slave  apb,
    input  logic [NUM_COLS-1:0]  COL_N,
    output logic                 IRQ
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [11:0] ADDR_STATUS = 12'h200;
    localparam logic [11:0] ADDR_POP    = 12'h204;
    localparam logic [11:0] ADDR_CTRL   = 12'h208;

    if (NUM_COLS < 1 || NUM_COLS > 8 || DEBOUNCE_BITS < 1 || FIFO_DEPTH < 2 ||
        FIFO_DEPTH > 128 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        LOCKOUT_CYCLES < 1) begin : g_param_check
        $error("column_event_queue: illegal parameter set");
    end

    typedef struct packed {
        logic [7:0] seq;
        logic [2:0] col;
    } entry_t;

    // ------------------------------------------------------------------ APB
    logic [11:0] addr;
    logic        setup, access, pop, ctrl_wr, flush;
    logic        unused_apb;

    assign addr       = apb.PADDR[11:0];
    assign setup      = apb.PSEL & ~apb.PENABLE;
    assign access     = apb.PSEL & apb.PENABLE;
    assign ctrl_wr    = access & apb.PWRITE & (addr == ADDR_CTRL);
    assign flush      = ctrl_wr & apb.PWDATA[1];
    assign unused_apb = ^{apb.PADDR[31:12], apb.PWDATA[31:3]};
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

    // ------------------------------------------------------ input conditioning
    logic [NUM_COLS-1:0]      meta_q, sync_q, stable_q, stable_dly_q, rise;
    logic [DEBOUNCE_BITS-1:0] db_cnt_q [NUM_COLS];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            meta_q       <= '0;
            sync_q       <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < NUM_COLS; i++) db_cnt_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, so meta_q -> sync_q really is two stages.
            meta_q       <= ~COL_N;
            sync_q       <= meta_q;
            stable_dly_q <= stable_q;
            for (int i = 0; i < NUM_COLS; i++) begin
                if (sync_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else begin
                    // Rolls over to zero on the same edge the state toggles.
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    if (&db_cnt_q[i]) stable_q[i] <= ~stable_q[i];
                end
            end
        end
    end

    assign rise = stable_q & ~stable_dly_q;

    // ---------------------------------------------------------- state regs
    logic [NUM_COLS-1:0] pending_q, pending_d, event_in, svc_onehot;
    logic                svc_valid, push, drop;
    logic [2:0]          svc_col;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]          seq_q, seq_d;
    logic                overflow_q, overflow_d, enable_q, enable_d;
    logic                empty, full, irq_q;
    logic [31:0]         prdata_q, rd_data;
    entry_t              mem_q [FIFO_DEPTH];
    entry_t              head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign head  = mem_q[rd_ptr_q];
    assign pop   = access & ~apb.PWRITE & (addr == ADDR_POP) & ~empty;

`ifdef LOCKOUT_EN
    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    logic [LOCK_W-1:0]   lock_q [NUM_COLS];
    logic [NUM_COLS-1:0] locked;

    always_comb begin
        for (int i = 0; i < NUM_COLS; i++) locked[i] = (lock_q[i] != '0);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_COLS; i++) lock_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_COLS; i++) begin
                if (flush)                    lock_q[i] <= '0;
                else if (svc_onehot[i])       lock_q[i] <= LOCK_W'(LOCKOUT_CYCLES);
                else if (locked[i])           lock_q[i] <= lock_q[i] - 1'b1;
            end
        end
    end

    assign event_in = rise & ~locked & {NUM_COLS{enable_q}};
`else
    assign event_in = rise & {NUM_COLS{enable_q}};
`endif

    // Fixed priority: the downward scan leaves the lowest pending index.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise the unassigned paths would infer latches.
        svc_valid  = 1'b0;
        svc_col    = '0;
        svc_onehot = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                svc_valid     = 1'b1;
                svc_col       = 3'(i);
                svc_onehot    = '0;
                svc_onehot[i] = 1'b1;
            end
        end
    end

    // A same-cycle pop frees the slot the push needs; flush discards the
    // arbiter result without counting it as an overflow.
    assign push = svc_valid & ~flush & (~full | pop);
    assign drop = svc_valid & ~flush & full & ~pop;

    always_comb begin
        pending_d  = (pending_q & ~svc_onehot) | event_in;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        seq_d      = seq_q + 8'(push);
        overflow_d = overflow_q;
        enable_d   = enable_q;
        if (ctrl_wr) begin
            enable_d = apb.PWDATA[2];
            if (apb.PWDATA[0]) overflow_d = 1'b0;
        end
        if (drop) overflow_d = 1'b1;
        if (flush) begin
            pending_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end
    end

    always_comb begin
        rd_data = '0;
        unique case (addr)
            ADDR_STATUS: rd_data = {20'h0, 8'(count_q), enable_q, overflow_q, full, empty};
            ADDR_POP:    rd_data = empty ? 32'h8000_0000 : {16'h0, head.seq, 5'h0, head.col};
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pending_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b1;
            irq_q      <= 1'b0;
            prdata_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            enable_q   <= enable_d;
            irq_q      <= ~empty;
            if (setup) prdata_q <= rd_data;
        end
    end

    // NOTE: the storage array has no reset; count/pointers decide validity
    // and empty reads are masked, so stale contents are never visible.
    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= '{seq: seq_q, col: svc_col};
    end

    assign apb.PRDATA = prdata_q;
    assign IRQ        = irq_q;
endmodule
